imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader for the instruction memory. It receives a byte stream (length header, little-endian instruction words, XOR checksum), assembles 32-bit words and writes them to consecutive instruction-memory word addresses from 0. The fetch unit reads the same memory, so the loader holds the core in reset for the whole load. It sits between the host byte link (UART receiver or testbench) and the instruction-memory write port.

## Interface
- ADDR_W, 8, instruction-memory word-address width (256 words); legal range 1..15
- clk  in  1  clock; all state changes on the rising edge
- resetn  in  1  synchronous, active-low reset
- load_req  in  1  one-cycle request to start a load; honoured only in IDLE, DONE or ERR
- in_valid  in  1  byte on in_data is valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle; transfer when in_valid && in_ready
- wr_en  out  1  one-cycle instruction-memory write strobe
- wr_addr  out  ADDR_W  word address of the write
- wr_data  out  32  word to write
- core_resetn  out  1  active-low reset to the core (fetch and downstream)
- busy  out  1  load in progress (LEN_LO, LEN_HI, DATA or CSUM)
- done  out  1  last load finished with a good checksum; sticky
- error  out  1  last load failed (length or checksum); sticky
- words_loaded  out  ADDR_W+1  words written in the current or last load

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE -> LEN_LO on load_req. DONE or ERR -> LEN_LO on load_req, which also clears done, error, words_loaded, checksum and the byte counter.
- LEN_LO: accepted byte gives N[7:0]. LEN_HI: accepted byte gives N[15:8].
- After LEN_HI:
  - N > 2**ADDR_W -> ERR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
- DATA: bytes are little-endian (first byte is wr_data[7:0]). A 2-bit byte counter tracks position. When the 4th byte is accepted, the word is written to address words_loaded, then words_loaded is incremented. After word N -> CSUM.
- Checksum: 8-bit running XOR, seed 0x00, covering both length bytes and all data bytes. In CSUM the accepted byte is compared: equal -> DONE, else -> ERR.
- in_ready = 1 only in LEN_LO, LEN_HI, DATA and CSUM; 0 in IDLE, DONE and ERR.
- core_resetn = 0 in LEN_LO through CSUM and in ERR; 1 in IDLE and DONE.
- load_req in LEN_LO through CSUM is ignored.
- Bytes presented while in_ready = 0 are not consumed.
- in_valid gaps of any length are tolerated; state holds.
- Memory contents written before an error or reset are left as-is; the core stays in reset in ERR.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - in_ready 0, wr_en 0, wr_addr 0, wr_data 0
  - core_resetn 0
  - busy 0, done 0, error 0, words_loaded 0
- core_resetn rises the first cycle after resetn deasserts (IDLE).
- load_req sampled at edge T: state is LEN_LO and in_ready = 1, busy = 1, core_resetn = 0 from T+1.
- 4th byte of a word accepted at edge T: wr_en = 1 with that wr_addr and wr_data for exactly the cycle after T; words_loaded updates at T+1.
- A checksum byte accepted in that same wr_en cycle is legal.
- Checksum byte accepted at edge T: done or error, plus the matching core_resetn value, are visible from T+1. Worst-case throughput is one byte per cycle.
- N = 2**ADDR_W: the last write goes to address 2**ADDR_W-1. wr_addr is never taken from a wrapped counter.
- resetn low at any edge, including mid-word or mid-checksum: every output returns to its reset value at that edge and any partial word is discarded.

## Test plan
- Load 2 words, stream 02 00 93 00 10 00 33 00 00 00, then B2 -> writes 0x00100093 @0 and 0x00000033 @1; done = 1, core_resetn = 1, words_loaded = 2.
- Same stream with checksum 0xB3 -> both writes still occur; error = 1, done = 0, core_resetn stays 0.
- Length 01 02 (N = 513 > 256) -> ERR immediately after the length bytes, no wr_en, in_ready = 0.
- N = 0: 00 00 then 00 -> DONE with no writes; N = 256 -> last write at address 0xFF, words_loaded = 256.
- in_valid toggling every other cycle, plus load_req pulsed mid-DATA -> identical writes and result to the back-to-back case; load_req has no effect.
- resetn low after 2 bytes of word 1 -> all outputs reset. A following load_req with a full stream loads correctly from address 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// slave: the loader side; master: the host link / memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses length / LE words / XOR checksum
// from a byte stream, writes words from address 0 and holds the core in reset.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_req,
  imem_loader_if.slave      bus,
  output logic              core_resetn,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       word_q, word_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              in_ready_q;
  logic              busy_q;
  logic              core_resetn_q;

  logic              accept;
  logic [16:0]       len_full;
  logic [ADDR_W:0]   wl_inc;

  // in_ready_q mirrors "state_q is a receiving state", so it doubles as the accept gate.
  assign accept   = bus.in_valid && in_ready_q;
  assign len_full = {1'b0, bus.in_data, len_q[7:0]};
  assign wl_inc   = wl_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    word_d     = word_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wl_d       = wl_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (load_req) begin
          state_d    = LEN_LO;
          done_d     = 1'b0;
          error_d    = 1'b0;
          wl_d       = '0;
          csum_d     = '0;
          byte_cnt_d = '0;
        end
      end

      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = bus.in_data;
          csum_d     = csum_q ^ bus.in_data;
          state_d    = LEN_HI;
        end
      end

      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = bus.in_data;
          csum_d      = csum_q ^ bus.in_data;
          if (len_full > MAX_WORDS) begin
            state_d = ERR;
            error_d = 1'b1;
          end else if (len_full == '0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ bus.in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_d[7:0]   = bus.in_data;
            2'd1: word_d[15:8]  = bus.in_data;
            2'd2: word_d[23:16] = bus.in_data;
            default: begin
              wr_en_d   = 1'b1;
              wr_addr_d = wl_q[ADDR_W-1:0];
              wr_data_d = {bus.in_data, word_q};
              wl_d      = wl_inc;
              if (17'(wl_inc) == {1'b0, len_q}) begin
                state_d = CSUM;
              end
            end
          endcase
        end
      end

      CSUM: begin
        if (accept) begin
          if (bus.in_data == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      len_q         <= '0;
      byte_cnt_q    <= '0;
      csum_q        <= '0;
      word_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wl_q          <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      core_resetn_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      byte_cnt_q    <= byte_cnt_d;
      csum_q        <= csum_d;
      word_q        <= word_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wl_q          <= wl_d;
      done_q        <= done_d;
      error_q       <= error_d;
      // State-decoded outputs are registered from the next state so they track state_q exactly.
      in_ready_q    <= (state_d inside {LEN_LO, LEN_HI, DATA, CSUM});
      busy_q        <= (state_d inside {LEN_LO, LEN_HI, DATA, CSUM});
      core_resetn_q <= (state_d == IDLE) || (state_d == DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign core_resetn   = core_resetn_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_loaded  = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, length limits, N=0/N=max,
// in_valid gaps with ignored load_req, and reset in the middle of a word.
module tb_imem_loader;
  localparam int unsigned ADDR_W = 8;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            load_req = 1'b0;
  logic            core_resetn;
  logic            busy;
  logic            done;
  logic            error;
  logic [ADDR_W:0] words_loaded;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  logic [31:0]       exp_d[$];
  logic [7:0]        stim[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .load_req     (load_req),
    .bus          (bus),
    .core_resetn  (core_resetn),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // wr_en is a one-cycle strobe, so each high cycle logs exactly one write.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  // gap: idle cycle after each byte; pulse_at: byte index before which load_req is pulsed
  task automatic send_stim(input bit gap, input int pulse_at);
    for (int i = 0; i < stim.size(); i++) begin
      if (i == pulse_at) start_load();
      send_byte(stim[i]);
      if (gap) tick();
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_two_words(input string tag);
    check({tag, "_wr_count"}, wa_q.size(), 32'd2);
    if (wa_q.size() == 2) begin
      check({tag, "_addr0"}, 32'(wa_q[0]), 32'd0);
      check({tag, "_data0"}, wd_q[0], 32'h0010_0093);
      check({tag, "_addr1"}, 32'(wa_q[1]), 32'd1);
      check({tag, "_data1"}, wd_q[1], 32'h0000_0033);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  x;
    logic [31:0] w;
    int unsigned mism;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values
    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_core_resetn", core_resetn, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_words", 32'(words_loaded), 32'd0);
    resetn = 1'b1;
    tick();
    check("idle_core_resetn", core_resetn, 1'b1);

    // Bytes offered in IDLE are not consumed
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h02;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    check("idle_in_ready", bus.in_ready, 1'b0);

    // Two-word load, good checksum
    clear_log();
    start_load();
    check("start_busy", busy, 1'b1);
    check("start_in_ready", bus.in_ready, 1'b1);
    check("start_core_resetn", core_resetn, 1'b0);
    stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'hB2};
    send_stim(1'b0, -1);
    check("good_done", done, 1'b1);
    check("good_error", error, 1'b0);
    check("good_core_resetn", core_resetn, 1'b1);
    check("good_busy", busy, 1'b0);
    check("good_words", 32'(words_loaded), 32'd2);
    check_two_words("good");

    // Same stream, bad checksum
    clear_log();
    start_load();
    check("reload_done_clr", done, 1'b0);
    stim[10] = 8'hB3;
    send_stim(1'b0, -1);
    check("bad_error", error, 1'b1);
    check("bad_done", done, 1'b0);
    check("bad_core_resetn", core_resetn, 1'b0);
    check("bad_in_ready", bus.in_ready, 1'b0);
    check("bad_words", 32'(words_loaded), 32'd2);
    check_two_words("bad");

    // Length 513 > 256
    clear_log();
    start_load();
    check("len_err_clr", error, 1'b0);
    check("len_words_clr", 32'(words_loaded), 32'd0);
    stim = '{8'h01, 8'h02};
    send_stim(1'b0, -1);
    check("len_error", error, 1'b1);
    check("len_in_ready", bus.in_ready, 1'b0);
    check("len_core_resetn", core_resetn, 1'b0);
    tick();
    check("len_wr_count", wa_q.size(), 32'd0);

    // N = 0
    clear_log();
    start_load();
    stim = '{8'h00, 8'h00, 8'h00};
    send_stim(1'b0, -1);
    check("n0_done", done, 1'b1);
    check("n0_error", error, 1'b0);
    check("n0_wr_count", wa_q.size(), 32'd0);

    // N = 256: fills the whole memory
    clear_log();
    stim.delete();
    exp_d.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h01);
    x = 8'h01;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i) ^ 8'hC3, 8'h5A, ~8'(i), 8'(i)};
      exp_d.push_back(w);
      for (int b = 0; b < 4; b++) begin
        stim.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    stim.push_back(x);
    start_load();
    send_stim(1'b0, -1);
    check("n256_done", done, 1'b1);
    check("n256_words", 32'(words_loaded), 32'd256);
    check("n256_wr_count", wa_q.size(), 32'd256);
    mism = 999;
    if (wa_q.size() == 256) begin
      mism = 0;
      for (int i = 0; i < 256; i++)
        if (32'(wa_q[i]) != 32'(i) || wd_q[i] != exp_d[i]) mism++;
      check("n256_last_addr", 32'(wa_q[255]), 32'hFF);
    end
    check("n256_mismatches", mism, 32'd0);

    // in_valid gaps with load_req pulsed mid-DATA
    clear_log();
    start_load();
    stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'hB2};
    send_stim(1'b1, 5);
    check("gap_done", done, 1'b1);
    check("gap_error", error, 1'b0);
    check("gap_words", 32'(words_loaded), 32'd2);
    check_two_words("gap");

    // Reset after two bytes of word 1
    clear_log();
    start_load();
    stim = '{8'h02, 8'h00, 8'h93, 8'h00};
    send_stim(1'b0, -1);
    resetn = 1'b0;
    tick();
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_core_resetn", core_resetn, 1'b0);
    check("mid_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("mid_rst_wr_data", bus.wr_data, 32'd0);
    check("mid_rst_done", done, 1'b0);
    resetn = 1'b1;
    tick();
    clear_log();
    start_load();
    stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'hB2};
    send_stim(1'b0, -1);
    check("after_rst_done", done, 1'b1);
    check("after_rst_words", 32'(words_loaded), 32'd2);
    check_two_words("after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
